// File: rtl/bombe_pkg.sv
// Shared definitions for the bombe search path: rotor geometry, plaintext base
// character and the search controller state encoding.
package bombe_pkg;

    localparam int         BOMBE_NPOS = 26;
    localparam int         POS_W      = 5;
    localparam logic [7:0] CHAR_A     = 8'h41;

    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_NEXT,
        ST_STEP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/bombe_search_ctrl_rotor_odometer.sv
// Three-digit mod-NPOS counter holding the candidate rotor start setting;
// r is the fastest digit and carries into m, then into l.
module rotor_odometer
    import bombe_pkg::*;
#(
    parameter int NPOS = BOMBE_NPOS
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_inc,
    output pos_t o_pos_l,
    output pos_t o_pos_m,
    output pos_t o_pos_r,
    output logic o_last
);

    localparam pos_t MAX_POS = pos_t'(NPOS - 1);

    pos_t r_pos_l;
    pos_t r_pos_m;
    pos_t r_pos_r;

    // NOTE: sequential state uses non-blocking assignments so every digit
    // updates from pre-edge values and simulation matches the flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pos_l <= '0;
            r_pos_m <= '0;
            r_pos_r <= '0;
        end else if (i_clear) begin
            r_pos_l <= '0;
            r_pos_m <= '0;
            r_pos_r <= '0;
        end else if (i_inc) begin
            if (r_pos_r == MAX_POS) begin
                r_pos_r <= '0;
                if (r_pos_m == MAX_POS) begin
                    r_pos_m <= '0;
                    r_pos_l <= (r_pos_l == MAX_POS) ? '0 : r_pos_l + pos_t'(1);
                end else begin
                    r_pos_m <= r_pos_m + pos_t'(1);
                end
            end else begin
                r_pos_r <= r_pos_r + pos_t'(1);
            end
        end
    end

    assign o_pos_l = r_pos_l;
    assign o_pos_m = r_pos_m;
    assign o_pos_r = r_pos_r;
    assign o_last  = (r_pos_l == MAX_POS) && (r_pos_m == MAX_POS) && (r_pos_r == MAX_POS);

endmodule

// File: rtl/bombe_search_ctrl.sv
// Bombe deduction sweep: walks every rotor start setting, encrypts "ABC" through
// the external Enigma engine and reports the first setting matching the flags.
module bombe_search_ctrl
    import bombe_pkg::*;
#(
    parameter int NPOS = BOMBE_NPOS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] flag_s1,
    input  logic [7:0] flag_s2,
    input  logic [7:0] flag_s3,
    output logic       enc_req,
    output logic [1:0] enc_idx,
    output logic [7:0] enc_plain,
    output pos_t       enc_pos_l,
    output pos_t       enc_pos_m,
    output pos_t       enc_pos_r,
    input  logic       enc_ack,
    input  logic [7:0] enc_char,
    output logic       busy,
    output logic       done,
    output logic       found,
    output pos_t       res_l,
    output pos_t       res_m,
    output pos_t       res_r
);

    state_t     r_state;
    logic [1:0] r_idx;
    logic       r_req;
    logic       r_busy;
    logic       r_done;
    logic       r_found;
    pos_t       r_res_l;
    pos_t       r_res_m;
    pos_t       r_res_r;
    logic [7:0] r_flag_1;
    logic [7:0] r_flag_2;
    logic [7:0] r_flag_3;

    logic       w_start_ok;
    logic       w_odo_clear;
    logic       w_odo_inc;
    logic       w_last;
    logic [7:0] w_flag_sel;
    logic       w_match;

    assign w_start_ok  = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_odo_clear = abort || w_start_ok;
    assign w_odo_inc   = (r_state == ST_STEP) && !w_last;

    rotor_odometer #(
        .NPOS (NPOS)
    ) u_odometer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_odo_clear),
        .i_inc   (w_odo_inc),
        .o_pos_l (enc_pos_l),
        .o_pos_m (enc_pos_m),
        .o_pos_r (enc_pos_r),
        .o_last  (w_last)
    );

    // NOTE: a default before the case keeps this block purely combinational;
    // without it an uncovered index would infer a latch.
    always_comb begin
        w_flag_sel = r_flag_1;
        case (r_idx)
            2'd1:    w_flag_sel = r_flag_2;
            2'd2:    w_flag_sel = r_flag_3;
            default: w_flag_sel = r_flag_1;
        endcase
    end

    assign w_match = (enc_char == w_flag_sel);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_req    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_res_l  <= '0;
            r_res_m  <= '0;
            r_res_r  <= '0;
            r_flag_1 <= '0;
            r_flag_2 <= '0;
            r_flag_3 <= '0;
        end else if (abort) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_found <= 1'b0;
            r_res_l <= '0;
            r_res_m <= '0;
            r_res_r <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_flag_1 <= flag_s1;
                        r_flag_2 <= flag_s2;
                        r_flag_3 <= flag_s3;
                        r_idx    <= '0;
                        r_req    <= 1'b1;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_found  <= 1'b0;
                        r_res_l  <= '0;
                        r_res_m  <= '0;
                        r_res_r  <= '0;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (enc_ack) begin
                        r_req <= 1'b0;
                        if (!w_match) begin
                            // Early-out: the remaining characters cannot rescue this candidate.
                            r_idx   <= '0;
                            r_state <= ST_STEP;
                        end else if (r_idx == 2'd2) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_found <= 1'b1;
                            r_res_l <= enc_pos_l;
                            r_res_m <= enc_pos_m;
                            r_res_r <= enc_pos_r;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            r_state <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    r_req   <= 1'b1;
                    r_state <= ST_REQ;
                end
                ST_STEP: begin
                    r_idx <= '0;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_found <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_req   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign enc_req   = r_req;
    assign enc_idx   = r_idx;
    assign enc_plain = CHAR_A + {6'b0, r_idx};
    assign busy      = r_busy;
    assign done      = r_done;
    assign found     = r_found;
    assign res_l     = r_res_l;
    assign res_m     = r_res_m;
    assign res_r     = r_res_r;

endmodule

// File: tb/tb_bombe_search_ctrl.sv
// Directed bench for bombe_search_ctrl: a behavioural Enigma engine answers the
// handshake and a scoreboard holds the expected outcome of each search.
module tb_bombe_search_ctrl;
    import bombe_pkg::*;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic [7:0] flag_s1 = '0;
    logic [7:0] flag_s2 = '0;
    logic [7:0] flag_s3 = '0;
    logic       enc_ack = 1'b0;
    logic [7:0] enc_char = '0;
    logic       enc_req;
    logic [1:0] enc_idx;
    logic [7:0] enc_plain;
    pos_t       enc_pos_l, enc_pos_m, enc_pos_r;
    logic       busy, done, found;
    pos_t       res_l, res_m, res_r;

    bombe_search_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .flag_s1   (flag_s1),
        .flag_s2   (flag_s2),
        .flag_s3   (flag_s3),
        .enc_req   (enc_req),
        .enc_idx   (enc_idx),
        .enc_plain (enc_plain),
        .enc_pos_l (enc_pos_l),
        .enc_pos_m (enc_pos_m),
        .enc_pos_r (enc_pos_r),
        .enc_ack   (enc_ack),
        .enc_char  (enc_char),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .res_l     (res_l),
        .res_m     (res_m),
        .res_r     (res_r)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic found;
        pos_t l, m, r;
        int   cycles;
        bit   chk_pos;
    } exp_t;
    exp_t sb_q[$];

    typedef enum {M_HIT, M_CARRY, M_NEVER, M_PARTIAL} mode_e;
    mode_e      mode      = M_HIT;
    logic [7:0] eng_flags [3];
    int         max_delay = 0;
    int         wait_cnt  = 0;
    int         cur_delay = 0;
    bit         hs_en     = 1'b0;
    bit         carry_seen = 1'b0;

    logic       p_req = 1'b0, p_ack = 1'b0;
    logic [24:0] p_bus = '0;

    function automatic logic [7:0] model_char(input logic [1:0] idx, input pos_t l, input pos_t m, input pos_t r);
        bit hit;
        case (mode)
            M_HIT:     hit = 1'b1;
            M_CARRY:   hit = (l == 5'd1) && (m == 5'd25) && (r == 5'd25);
            M_PARTIAL: hit = (idx == 2'd0) || (idx == 2'd1 && r[0]) || (idx == 2'd2 && r == 5'd5);
            default:   hit = 1'b0;
        endcase
        return hit ? eng_flags[idx] : ~eng_flags[idx];
    endfunction

    // Engine model plus handshake protocol monitor, both on the falling edge.
    always @(negedge clk) begin
        if (hs_en && reset) begin
            if (p_req && !p_ack) begin
                check("hs_req_hold", enc_req, 1);
                check("hs_stable", {enc_idx, enc_plain, enc_pos_l, enc_pos_m, enc_pos_r}, p_bus);
            end
            if (p_req && p_ack) check("hs_rtz", enc_req, 0);
            if (enc_req) begin
                check("hs_plain", enc_plain, 8'h41 + 8'(enc_idx));
                check("hs_pos_range", (enc_pos_l < 26) && (enc_pos_m < 26) && (enc_pos_r < 26), 1);
            end
        end
        if (enc_req && !enc_ack) begin
            if (wait_cnt >= cur_delay) begin
                enc_ack  = 1'b1;
                enc_char = model_char(enc_idx, enc_pos_l, enc_pos_m, enc_pos_r);
            end else begin
                wait_cnt++;
            end
        end else begin
            enc_ack   = 1'b0;
            enc_char  = 8'h00;
            wait_cnt  = 0;
            cur_delay = $urandom_range(max_delay, 0);
        end
        p_req = enc_req;
        p_ack = enc_ack;
        p_bus = {enc_idx, enc_plain, enc_pos_l, enc_pos_m, enc_pos_r};
    end

    task automatic set_flags(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        flag_s1 = a;
        flag_s2 = b;
        flag_s3 = c;
        eng_flags[0] = a;
        eng_flags[1] = b;
        eng_flags[2] = c;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_search(input string tag, input int budget, input int late_at);
        int   cycles;
        exp_t e;
        logic [14:0] prev;
        pulse_start();
        check({tag, "_start_busy"}, busy, 1);
        check({tag, "_start_req"}, enc_req, 1);
        check({tag, "_start_pos"}, {enc_pos_l, enc_pos_m, enc_pos_r}, 0);
        cycles = 0;
        while (!done && cycles < budget) begin
            prev = {enc_pos_l, enc_pos_m, enc_pos_r};
            if (cycles == late_at) begin
                flag_s1 = "Z";
                flag_s2 = "Z";
                flag_s3 = "Z";
                start   = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            cycles++;
            if (prev == {5'd0, 5'd25, 5'd25} && {enc_pos_l, enc_pos_m, enc_pos_r} != prev) begin
                carry_seen = 1'b1;
                check("carry_step", {enc_pos_l, enc_pos_m, enc_pos_r}, {5'd1, 5'd0, 5'd0});
            end
        end
        check({tag, "_done_in_budget"}, done, 1);
        check({tag, "_sb_nonempty"}, sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_found"}, found, e.found);
            check({tag, "_busy_low"}, busy, 0);
            if (e.found) check({tag, "_res"}, {res_l, res_m, res_r}, {e.l, e.m, e.r});
            if (e.cycles >= 0) check({tag, "_latency"}, cycles, e.cycles);
            if (e.chk_pos) check({tag, "_final_pos"}, {enc_pos_l, enc_pos_m, enc_pos_r}, {e.l, e.m, e.r});
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_sticky"}, done, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"}, enc_req, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done_found"}, {done, found}, 0);
        check({tag, "_idx_plain"}, {enc_idx, enc_plain}, {2'd0, 8'h41});
        check({tag, "_pos"}, {enc_pos_l, enc_pos_m, enc_pos_r}, 0);
        check({tag, "_res"}, {res_l, res_m, res_r}, 0);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk) reset = 1'b1;

        // Hit at 0/0/0 with a zero-wait engine
        mode = M_HIT;
        set_flags("Q", "W", "E");
        sb_q.push_back('{found: 1'b1, l: 5'd0, m: 5'd0, r: 5'd0, cycles: 5, chk_pos: 1'b0});
        run_search("hit", 50, -1);

        // Carry chain: match only at 1/25/25
        mode = M_CARRY;
        set_flags("X", "Y", "Z");
        carry_seen = 1'b0;
        sb_q.push_back('{found: 1'b1, l: 5'd1, m: 5'd25, r: 5'd25, cycles: 1351 * 2 + 5, chk_pos: 1'b0});
        run_search("carry", 5000, -1);
        check("carry_seen", carry_seen, 1);

        // Random ack delays, partial matches, and a start pulse while busy
        mode      = M_PARTIAL;
        max_delay = 5;
        set_flags("B", "M", "B");
        hs_en = 1'b1;
        sb_q.push_back('{found: 1'b1, l: 5'd0, m: 5'd0, r: 5'd5, cycles: -1, chk_pos: 1'b0});
        run_search("handshake", 500, 10);
        hs_en     = 1'b0;
        max_delay = 0;

        // Exhaustion: every candidate mismatches on the first character
        mode = M_NEVER;
        set_flags("K", "L", "M");
        sb_q.push_back('{found: 1'b0, l: 5'd25, m: 5'd25, r: 5'd25, cycles: 35152, chk_pos: 1'b1});
        run_search("exhaust", 40000, -1);

        // Abort during REQ at candidate 0/3/7, with a same-cycle ack
        mode = M_NEVER;
        pulse_start();
        n = 0;
        while (!({enc_pos_l, enc_pos_m, enc_pos_r} == {5'd0, 5'd3, 5'd7} && enc_req) && n < 2000) begin
            @(posedge clk);
            #1 n++;
        end
        check("abort_reached_target", n < 2000, 1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check_idle_outputs("abort");
        mode = M_HIT;
        set_flags("Q", "W", "E");
        sb_q.push_back('{found: 1'b1, l: 5'd0, m: 5'd0, r: 5'd0, cycles: 5, chk_pos: 1'b0});
        run_search("restart", 50, -1);

        // Asynchronous reset in the middle of a STEP cycle
        mode = M_NEVER;
        pulse_start();
        n = 0;
        while (!(enc_pos_r >= 5'd3 && busy && !enc_req) && n < 2000) begin
            @(posedge clk);
            #1 n++;
        end
        check("step_reached", n < 2000, 1);
        #2 reset = 1'b0;
        #1 check_idle_outputs("async_reset");
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 check("post_reset_idle", {busy, done, enc_req}, 0);

        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
